seg7_mux_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_mux_driver_if.sv | 26 ++
 rtl/seg7_hex_encoder.sv | 11 +
 rtl/seg7_mux_driver.sv | 168 ++++++++++++++++
 tb/tb_seg7_mux_driver.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-high unless a helper says otherwise.
package seg7_pkg;

   localparam int unsigned SegA     = 0;
   localparam int unsigned SegB     = 1;
   localparam int unsigned SegC     = 2;
   localparam int unsigned SegD     = 3;
   localparam int unsigned SegE     = 4;
   localparam int unsigned SegF     = 5;
   localparam int unsigned SegG     = 6;
   localparam int unsigned SegCount = SegG + 1;

   // Index is the hex nibble; lowercase b and d keep them distinct from 8 and 0.
   localparam logic [SegCount-1:0] HexGlyph [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   function automatic logic [SegCount-1:0] seg_inactive(bit active_low);
      return active_low ? 7'h7F : 7'h00;
   endfunction

   function automatic logic seg_dp_inactive(bit active_low);
      return active_low;
   endfunction

   // Wide enough for the largest legal digit count; callers slice to N_DIGITS.
   function automatic logic [7:0] an_inactive(bit active_low);
      return active_low ? 8'hFF : 8'h00;
   endfunction

endpackage

// File: rtl/seg7_mux_driver_if.sv
// Producer-side bundle of the display driver: value staging inputs and pin outputs.
// master = value producer / board, slave = seg7_mux_driver.
interface seg7_mux_driver_if #(
   parameter int unsigned N_DIGITS = 4
);

   logic                  load;
   logic [4*N_DIGITS-1:0] value;
   logic [N_DIGITS-1:0]   dp;
   logic                  blank_en;
   logic [6:0]            seg;
   logic                  seg_dp;
   logic [N_DIGITS-1:0]   an;
   logic                  frame_tick;

   modport master (
      output load, value, dp, blank_en,
      input  seg, seg_dp, an, frame_tick
   );

   modport slave (
      input  load, value, dp, blank_en,
      output seg, seg_dp, an, frame_tick
   );

endinterface

// File: rtl/seg7_hex_encoder.sv
// Combinational hex nibble to active-high 7-segment glyph.
module seg7_hex_encoder
   import seg7_pkg::*;
(
   input  logic [3:0]          nibble,
   output logic [SegCount-1:0] seg
);

   assign seg = HexGlyph[nibble];

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-synchronous shadow updates,
// leading-zero suppression and per-slot anti-ghosting blanking. All pins are registered.
module seg7_mux_driver
   import seg7_pkg::*;
#(
   parameter int unsigned N_DIGITS       = 4,
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned BLANK_CYC      = 2,
   parameter bit          LZ_SUPPRESS    = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input logic               clk,
   input logic               rst,
   seg7_mux_driver_if.slave  bus
);

   localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DigW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int unsigned ValW = 4 * N_DIGITS;

   localparam logic [PreW-1:0]     PreLast  = PreW'(SCAN_DIV - 1);
   localparam logic [PreW-1:0]     BlankEnd = PreW'(BLANK_CYC);
   localparam logic [DigW-1:0]     DigLast  = DigW'(N_DIGITS - 1);
   localparam logic [7:0]          AnOffAll = an_inactive(AN_ACTIVE_LOW);
   localparam logic [N_DIGITS-1:0] AnOff    = AnOffAll[N_DIGITS-1:0];
   localparam logic [6:0]          SegOff   = seg_inactive(SEG_ACTIVE_LOW);
   localparam logic                SegDpOff = seg_dp_inactive(SEG_ACTIVE_LOW);

   if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_n_digits
      $error("seg7_mux_driver: N_DIGITS must be in 1..8");
   end
   if (SCAN_DIV < 2) begin : g_bad_scan_div
      $error("seg7_mux_driver: SCAN_DIV must be at least 2");
   end
   if (BLANK_CYC >= SCAN_DIV) begin : g_bad_blank_cyc
      $error("seg7_mux_driver: BLANK_CYC must be less than SCAN_DIV");
   end

   // Scan counters
   logic [PreW-1:0] pre_q, pre_d;
   logic [DigW-1:0] dig_q, dig_d;
   logic            pre_last, dig_last, boundary;

   // Staging: pending holds the latest load, shadow is what the scan reads
   logic [ValW-1:0]     shadow_val_q, shadow_val_d;
   logic [N_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
   logic [ValW-1:0]     pend_val_q, pend_val_d;
   logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d;
   logic                pend_flag_q, pend_flag_d;

   // Output registers
   logic [6:0]          seg_q, seg_d;
   logic                seg_dp_q, seg_dp_d;
   logic [N_DIGITS-1:0] an_q, an_d;
   logic                frame_tick_q, frame_tick_d;

   // Current-digit decode
   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic [N_DIGITS-1:0] an_onehot;
   logic                upper_nonzero;
   logic                suppress;
   logic                blank;
   logic [6:0]          glyph;

   assign pre_last = (pre_q == PreLast);
   assign dig_last = (dig_q == DigLast);
   assign boundary = pre_last & dig_last;

   always_comb begin
      pre_d = pre_last ? '0 : pre_q + 1'b1;
      dig_d = dig_q;
      if (pre_last) begin
         dig_d = dig_last ? '0 : dig_q + 1'b1;
      end
   end

   // A load in the boundary cycle bypasses pending so it is shown without a frame of delay.
   always_comb begin
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      pend_val_d   = pend_val_q;
      pend_dp_d    = pend_dp_q;
      pend_flag_d  = pend_flag_q;
      if (boundary) begin
         if (bus.load) begin
            shadow_val_d = bus.value;
            shadow_dp_d  = bus.dp;
         end else if (pend_flag_q) begin
            shadow_val_d = pend_val_q;
            shadow_dp_d  = pend_dp_q;
         end
         pend_flag_d = 1'b0;
      end else if (bus.load) begin
         pend_val_d  = bus.value;
         pend_dp_d   = bus.dp;
         pend_flag_d = 1'b1;
      end
   end

   // A digit is a leading zero when it and every more-significant nibble are zero.
   always_comb begin
      cur_nib       = 4'h0;
      cur_dp        = 1'b0;
      an_onehot     = '0;
      upper_nonzero = 1'b0;
      for (int i = 0; i < int'(N_DIGITS); i++) begin
         if (DigW'(i) == dig_q) begin
            cur_nib      = shadow_val_q[4*i +: 4];
            cur_dp       = shadow_dp_q[i];
            an_onehot[i] = 1'b1;
         end
         if (DigW'(i) >= dig_q && shadow_val_q[4*i +: 4] != 4'h0) begin
            upper_nonzero = 1'b1;
         end
      end
   end

   seg7_hex_encoder u_hex_encoder (
      .nibble (cur_nib),
      .seg    (glyph)
   );

   assign suppress = LZ_SUPPRESS && (dig_q != '0) && !upper_nonzero;
   assign blank    = (pre_q < BlankEnd) || bus.blank_en;

   always_comb begin
      seg_d        = (suppress ? 7'h00 : glyph) ^ SegOff;
      seg_dp_d     = cur_dp ^ SegDpOff;
      an_d         = (blank ? '0 : an_onehot) ^ AnOff;
      frame_tick_d = boundary;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q        <= '0;
         dig_q        <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         pend_flag_q  <= 1'b0;
         seg_q        <= SegOff;
         seg_dp_q     <= SegDpOff;
         an_q         <= AnOff;
         frame_tick_q <= 1'b0;
      end else begin
         pre_q        <= pre_d;
         dig_q        <= dig_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         pend_flag_q  <= pend_flag_d;
         seg_q        <= seg_d;
         seg_dp_q     <= seg_dp_d;
         an_q         <= an_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.seg_dp     = seg_dp_q;
   assign bus.an         = an_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Bench for seg7_mux_driver: frame-level reference model compared every cycle,
// plus directed scenarios with literal pin expectations.
module tb_seg7_mux_driver;

   localparam int SD    = 4;
   localparam int ND    = 4;
   localparam int BLANK = 1;
   localparam int FRAME = SD * ND;

   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef struct packed {
      logic [6:0] seg;
      logic       seg_dp;
      logic [3:0] an;
      logic       tick;
   } pins_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   seg7_mux_driver_if #(.N_DIGITS(ND)) bus ();

   seg7_mux_driver #(
      .N_DIGITS       (ND),
      .SCAN_DIV       (SD),
      .BLANK_CYC      (BLANK),
      .LZ_SUPPRESS    (1'b1),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: cycle index within the frame since reset, shadow and pending.
   int          m_n = 0;
   logic [15:0] m_sh_val = '0;
   logic [3:0]  m_sh_dp = '0;
   logic [15:0] m_pd_val = '0;
   logic [3:0]  m_pd_dp = '0;
   logic        m_pd_flag = 1'b0;
   pins_t       exp_pins;
   logic        exp_valid = 1'b0;

   function automatic pins_t model_pins(int n, logic [15:0] v, logic [3:0] d, logic blk);
      pins_t       p;
      int          phase;
      int          dig;
      logic [15:0] upper;
      logic [6:0]  g;
      phase = n % SD;
      dig   = (n / SD) % ND;
      upper = v >> (4 * dig);
      g     = GLYPH[upper[3:0]];
      if (dig > 0 && upper == 16'h0) g = 7'h00;
      p.seg    = ~g;
      p.seg_dp = ~d[dig];
      p.an     = (phase < BLANK || blk) ? 4'hF : ~(4'b0001 << dig);
      p.tick   = ((n % FRAME) == FRAME - 1);
      return p;
   endfunction

   always @(posedge clk) begin
      exp_valid <= 1'b1;
      if (rst) begin
         m_n       <= 0;
         m_sh_val  <= '0;
         m_sh_dp   <= '0;
         m_pd_val  <= '0;
         m_pd_dp   <= '0;
         m_pd_flag <= 1'b0;
         exp_pins  <= '{seg: 7'h7F, seg_dp: 1'b1, an: 4'hF, tick: 1'b0};
      end else begin
         exp_pins <= model_pins(m_n, m_sh_val, m_sh_dp, bus.blank_en);
         m_n      <= (m_n + 1) % FRAME;
         if ((m_n % FRAME) == FRAME - 1) begin
            if (bus.load) begin
               m_sh_val <= bus.value;
               m_sh_dp  <= bus.dp;
            end else if (m_pd_flag) begin
               m_sh_val <= m_pd_val;
               m_sh_dp  <= m_pd_dp;
            end
            m_pd_flag <= 1'b0;
         end else if (bus.load) begin
            m_pd_val  <= bus.value;
            m_pd_dp   <= bus.dp;
            m_pd_flag <= 1'b1;
         end
      end
   end

   // Advances one cycle and compares all pins against the model at the falling edge.
   task automatic step();
      pins_t act;
      @(negedge clk);
      if (exp_valid) begin
         act = {bus.seg, bus.seg_dp, bus.an, bus.frame_tick};
         checks++;
         if (act !== exp_pins) begin
            errors++;
            $display("FAIL model_pins t=%0t: got seg=%h dp=%b an=%h tick=%b, expected seg=%h dp=%b an=%h tick=%b",
                     $time, act.seg, act.seg_dp, act.an, act.tick,
                     exp_pins.seg, exp_pins.seg_dp, exp_pins.an, exp_pins.tick);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s t=%0t: got %h, expected %h", name, $time, act, expv);
      end
   endtask

   task automatic wait_tick();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 3 * FRAME && !seen; i++) begin
         step();
         if (bus.frame_tick === 1'b1) seen = 1'b1;
      end
      chk("frame_tick_seen", {31'b0, seen}, 32'd1);
   endtask

   task automatic load_val(input logic [15:0] v, input logic [3:0] d);
      bus.load  = 1'b1;
      bus.value = v;
      bus.dp    = d;
      step();
      bus.load = 1'b0;
   endtask

   // Called in the frame_tick cycle; checks one full frame and ends on the next frame_tick.
   task automatic check_frame(input string name, input logic [3:0][6:0] segs,
                              input logic [3:0] dpn);
      int         s;
      int         pos;
      logic [3:0] an_exp;
      for (int k = 0; k < FRAME; k++) begin
         step();
         s      = k / SD;
         pos    = k % SD;
         an_exp = (pos == 0) ? 4'hF : ~(4'b0001 << s);
         chk({name, "_an"}, {28'b0, bus.an}, {28'b0, an_exp});
         chk({name, "_seg"}, {25'b0, bus.seg}, {25'b0, segs[s]});
         chk({name, "_dp"}, {31'b0, bus.seg_dp}, {31'b0, dpn[s]});
         chk({name, "_tick"}, {31'b0, bus.frame_tick}, {31'b0, (k == FRAME - 1)});
      end
   endtask

   initial begin
      bus.load     = 1'b0;
      bus.value    = '0;
      bus.dp       = '0;
      bus.blank_en = 1'b0;

      // Reset held for three cycles
      repeat (3) begin
         step();
         chk("rst_seg", {25'b0, bus.seg}, 32'h7F);
         chk("rst_dp", {31'b0, bus.seg_dp}, 32'd1);
         chk("rst_an", {28'b0, bus.an}, 32'hF);
      end
      rst = 1'b0;
      step();
      chk("release_blank_an", {28'b0, bus.an}, 32'hF);
      step();
      chk("release_digit0_an", {28'b0, bus.an}, 32'hE);

      // Scan order
      load_val(16'h1234, 4'b0000);
      wait_tick();
      check_frame("scan", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);

      // Tear-free update: second load lands mid-frame at digit 2
      load_val(16'h1111, 4'b0000);
      wait_tick();
      repeat (9) begin
         step();
         chk("tear_old_seg", {25'b0, bus.seg}, 32'h79);
      end
      load_val(16'hABCD, 4'b0000);
      chk("tear_old_seg", {25'b0, bus.seg}, 32'h79);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (bus.frame_tick === 1'b1) seen = 1'b1;
            else chk("tear_old_seg", {25'b0, bus.seg}, 32'h79);
         end
         chk("tear_tick_seen", {31'b0, seen}, 32'd1);
      end
      check_frame("tear_new", {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF);

      // Leading-zero suppression with a decimal point on a suppressed digit
      load_val(16'h0050, 4'b0100);
      wait_tick();
      check_frame("lz", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1011);

      // Load exactly in the boundary cycle
      repeat (15) step();
      chk("bnd_pend_before", {31'b0, dut.pend_flag_q}, 32'd0);
      load_val(16'h8888, 4'b0000);
      chk("bnd_tick", {31'b0, bus.frame_tick}, 32'd1);
      chk("bnd_pend_after", {31'b0, dut.pend_flag_q}, 32'd0);
      check_frame("bnd", {7'h00, 7'h00, 7'h00, 7'h00}, 4'hF);
      chk("bnd_pend_end", {31'b0, dut.pend_flag_q}, 32'd0);

      // blank_en held for ten cycles starting three cycles into the frame
      repeat (3) step();
      bus.blank_en = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step();
         chk("blank_an", {28'b0, bus.an}, 32'hF);
         if (i == 10) bus.blank_en = 1'b0;
      end
      step();
      chk("unblank_an", {28'b0, bus.an}, 32'h7);
      step();
      chk("unblank_tick0", {31'b0, bus.frame_tick}, 32'd0);
      step();
      chk("unblank_tick1", {31'b0, bus.frame_tick}, 32'd1);

      // Mid-frame reset discards a pending load
      repeat (3) step();
      load_val(16'h4321, 4'b1111);
      repeat (2) step();
      rst = 1'b1;
      repeat (2) begin
         step();
         chk("midrst_seg", {25'b0, bus.seg}, 32'h7F);
         chk("midrst_an", {28'b0, bus.an}, 32'hF);
         chk("midrst_tick", {31'b0, bus.frame_tick}, 32'd0);
      end
      chk("midrst_pend", {31'b0, dut.pend_flag_q}, 32'd0);
      rst = 1'b0;
      wait_tick();
      check_frame("post_rst", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
